// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
// Drives one DSP48A1 slice (A1REG=B1REG=MREG=PREG=OPMODEREG=1) as a signed
// multiply-accumulate engine and computes the dot product of LEN operand
// pairs streamed over a valid/ready handshake.
//
// Slice pipeline, counted from the edge that loads dsp_a/dsp_b:
//   +1 A1/B1 capture, +2 M and OPMODE capture, +3 P update.
// Each transfer pushes a tag into a LAT-deep shift register. dsp_opmode is
// registered from tag stage 1, so the slice opmode register captures the
// matching opmode on the same edge that M captures the matching product.
// Bubbles carry a null tag and produce HOLD (X=0, Z=P), so input stalls
// never disturb the running sum.
module dsp_mac_sequencer #(
  parameter int LEN_W = 10,
  parameter int LAT   = 3
) (
  input  logic             clk,
  input  logic             rstn,
  // command
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  // operand stream
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  // DSP48A1 slice
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_p,
  // result
  output logic             res_valid,
  output logic [47:0]      res_data,
  input  logic             res_ready
);

  // Slice opmodes (carry-in and pre-adder unused)
  localparam logic [7:0] OPM_HOLD = 8'h08;  // X=0, Z=P
  localparam logic [7:0] OPM_LOAD = 8'h01;  // X=M, Z=0
  localparam logic [7:0] OPM_ACC  = 8'h09;  // X=M, Z=P

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  // Per-slot pipeline tag travelling alongside the operand through the slice
  typedef struct packed {
    logic issued;  // slot carries a real operand pair
    logic first;   // first pair of the vector: start a fresh sum
    logic last;    // last pair of the vector
  } tag_t;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [17:0]      a_q, a_d;
  logic [17:0]      b_q, b_d;
  logic [7:0]       opmode_q, opmode_d;
  tag_t [LAT-1:0]   tag_q, tag_d;
  tag_t             new_tag;
  logic             last_exit_q, last_exit_d;
  logic [47:0]      res_q, res_d;

  logic             xfer;
  logic             is_last;

  // Handshake decode
  assign in_ready = (state_q == S_RUN) && (issued_q < len_q);
  assign xfer     = in_valid && in_ready;
  assign is_last  = ((issued_q + LEN_ONE) == len_q);

  // Registered outputs
  assign dsp_a      = a_q;
  assign dsp_b      = b_q;
  assign dsp_opmode = opmode_q;
  assign res_data   = res_q;

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state is always written with <= so every register
    // samples the pre-edge value of every other register.
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and state-decoded control outputs
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    busy      = (state_q != S_IDLE);
    dsp_ce    = 1'b0;
    dsp_rst   = 1'b0;
    res_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len == '0) ? S_DONE : S_CLR;
        end
      end
      S_CLR: begin
        // One-cycle clear of M, P and the opmode register
        dsp_ce  = 1'b1;
        dsp_rst = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        dsp_ce = 1'b1;
        if (xfer && is_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        dsp_ce = 1'b1;
        if (last_exit_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over start, transfers and result acceptance
    if (abort) begin
      state_d = S_IDLE;
    end
  end

  // Datapath next state: operand registers, tag pipeline, opmode, result
  always_comb begin
    len_d       = len_q;
    issued_d    = issued_q;
    a_d         = a_q;
    b_d         = b_q;
    last_exit_d = last_exit_q;
    res_d       = res_q;
    new_tag     = '0;

    // Operand capture; a cycle without transfer pushes a null tag
    if (xfer) begin
      new_tag.issued = 1'b1;
      new_tag.first  = (issued_q == '0);
      new_tag.last   = is_last;
      a_d            = in_a;
      b_d            = in_b;
      issued_d       = issued_q + LEN_ONE;
    end

    tag_d[0] = new_tag;
    for (int i = 1; i < LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    // Opmode follows tag stage 1 so it meets its product in the slice
    if (tag_q[0].issued && tag_q[0].first) begin
      opmode_d = OPM_LOAD;
    end else if (tag_q[0].issued) begin
      opmode_d = OPM_ACC;
    end else begin
      opmode_d = OPM_HOLD;
    end

    // Command capture; an empty vector yields a zero result directly
    if ((state_q == S_IDLE) && start) begin
      len_d       = len;
      issued_d    = '0;
      last_exit_d = 1'b0;
      if (len == '0) begin
        res_d = '0;
      end
    end

    // The final P is valid one edge after the last tag leaves stage LAT
    if (state_q == S_DRAIN) begin
      if (last_exit_q) begin
        res_d       = dsp_p;
        last_exit_d = 1'b0;
      end else if (tag_q[LAT-1].issued && tag_q[LAT-1].last) begin
        last_exit_d = 1'b1;
      end
    end

    // Abort flushes everything back to the reset picture
    if (abort) begin
      len_d       = '0;
      issued_d    = '0;
      a_d         = '0;
      b_d         = '0;
      opmode_d    = OPM_HOLD;
      tag_d       = '0;
      last_exit_d = 1'b0;
      res_d       = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: the tag pipeline is a handful of flops, not a RAM, and is reset
    // so a reset in mid-vector can never leak a stale tag into a new run.
    if (!rstn) begin
      len_q       <= '0;
      issued_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      opmode_q    <= OPM_HOLD;
      tag_q       <= '0;
      last_exit_q <= 1'b0;
      res_q       <= '0;
    end else begin
      len_q       <= len_d;
      issued_q    <= issued_d;
      a_q         <= a_d;
      b_q         <= b_d;
      opmode_q    <= opmode_d;
      tag_q       <= tag_d;
      last_exit_q <= last_exit_d;
      res_q       <= res_d;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer
// Directed bench for dsp_mac_sequencer driving a behavioural DSP48A1 slice
// (A1/B1/M/P/OPMODE registers, common CE, sync reset of M/P/OPMODE).
// Expected results and latencies are pushed to a scoreboard when a command
// is issued and popped when res_valid is seen. Inputs are driven and outputs
// sampled on the falling edge. Latency is counted in rising edges from the
// cycle in which start is driven to the cycle in which res_valid is seen.
module tb_dsp_mac_sequencer;

  localparam int LEN_W = 10;
  localparam int LAT   = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [17:0]      in_a;
  logic [17:0]      in_b;
  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce;
  logic             dsp_rst;
  logic [47:0]      dsp_p;
  logic             res_valid;
  logic [47:0]      res_data;
  logic             res_ready;

  dsp_mac_sequencer #(.LEN_W(LEN_W), .LAT(LAT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_opmode (dsp_opmode),
    .dsp_ce     (dsp_ce),
    .dsp_rst    (dsp_rst),
    .dsp_p      (dsp_p),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready)
  );

  always #5 clk = ~clk;

  // ---------------- DSP48A1 slice model ----------------
  logic signed [17:0] sl_a1  = '0;
  logic signed [17:0] sl_b1  = '0;
  logic signed [35:0] sl_m   = '0;
  logic [7:0]         sl_opm = '0;
  logic [47:0]        sl_p   = '0;
  logic [47:0]        sl_x;
  logic [47:0]        sl_z;

  assign sl_x  = (sl_opm[1:0] == 2'b01) ? {{12{sl_m[35]}}, sl_m} : 48'd0;
  assign sl_z  = (sl_opm[3:2] == 2'b10) ? sl_p : 48'd0;
  assign dsp_p = sl_p;

  always @(posedge clk) begin
    if (dsp_ce) begin
      sl_a1 <= dsp_a;
      sl_b1 <= dsp_b;
    end
    if (dsp_rst) begin
      sl_m   <= '0;
      sl_opm <= '0;
      sl_p   <= '0;
    end else if (dsp_ce) begin
      sl_m   <= sl_a1 * sl_b1;
      sl_opm <= dsp_opmode;
      sl_p   <= sl_x + sl_z;
    end
  end

  // ---------------- bookkeeping ----------------
  int cyc      = 0;
  int ce_count = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dsp_ce) ce_count <= ce_count + 1;

  typedef struct {
    logic [47:0] data;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          c_start = 0;
  logic [17:0] va[8];
  logic [17:0] vb[8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reset-picture of every control/slice output
  task automatic check_idle(input string tag);
    check({tag, "_busy"},     64'(busy),       64'd0);
    check({tag, "_in_ready"}, 64'(in_ready),   64'd0);
    check({tag, "_dsp_a"},    64'(dsp_a),      64'd0);
    check({tag, "_dsp_b"},    64'(dsp_b),      64'd0);
    check({tag, "_opmode"},   64'(dsp_opmode), 64'h08);
    check({tag, "_ce"},       64'(dsp_ce),     64'd0);
    check({tag, "_rst"},      64'(dsp_rst),    64'd0);
    check({tag, "_res_vld"},  64'(res_valid),  64'd0);
  endtask

  // Drive a one-cycle start; returns just after the accepting edge
  task automatic start_cmd(input logic [LEN_W-1:0] l);
    start   = 1'b1;
    len     = l;
    c_start = cyc;
    @(negedge clk);
    start = 1'b0;
    len   = '0;
  endtask

  // Stream n pairs from va/vb with gap idle cycles between pairs
  task automatic stream(input int n, input int gap);
    int guard;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_a     = va[i];
      in_b     = vb[i];
      guard    = 0;
      while (!in_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        check("ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (gap > 0 && i < n - 1) begin
        @(negedge clk);
        check("opm_aligned", 64'(dsp_opmode), (i == 0) ? 64'h01 : 64'h09);
        for (int g = 1; g < gap; g++) begin
          @(negedge clk);
          check("opm_stall_hold", 64'(dsp_opmode), 64'h08);
        end
      end
    end
  endtask

  // Wait for a result and compare against the scoreboard head
  task automatic wait_result(input string tag);
    int   guard;
    exp_t e;
    guard = 0;
    while (!res_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_res_valid"}, 64'(res_valid), 64'd1);
    if (res_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_res_data"}, 64'(res_data), 64'(e.data));
      check({tag, "_latency"}, 64'(cyc - c_start), 64'(e.lat));
    end
    if (res_ready) begin
      @(negedge clk);
      check({tag, "_pulse"}, 64'(res_valid), 64'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ce0;
    int hits;

    rstn      = 1'b0;
    start     = 1'b0;
    len       = '0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset_res_data", 64'(res_data), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Dot product, no stalls: 1*5+2*6+3*7+4*8
    va[0] = 18'd1; va[1] = 18'd2; va[2] = 18'd3; va[3] = 18'd4;
    vb[0] = 18'd5; vb[1] = 18'd6; vb[2] = 18'd7; vb[3] = 18'd8;
    exp_q.push_back('{data: 48'd70, lat: 10});
    start_cmd(10'd4);
    check("clr_rst",  64'(dsp_rst), 64'd1);
    check("clr_ce",   64'(dsp_ce),  64'd1);
    check("clr_busy", 64'(busy),    64'd1);
    stream(4, 0);
    wait_result("vec4");

    // Same vector with two idle cycles between pairs (6 stall cycles)
    exp_q.push_back('{data: 48'd70, lat: 16});
    start_cmd(10'd4);
    stream(4, 2);
    wait_result("vec4_gaps");

    // Negative operand: -2 * 3
    va[0] = 18'h3FFFE; vb[0] = 18'd3;
    exp_q.push_back('{data: 48'hFFFF_FFFF_FFFA, lat: 7});
    start_cmd(10'd1);
    stream(1, 0);
    wait_result("neg");

    // Empty vector: immediate zero result, slice never enabled
    ce0 = ce_count;
    exp_q.push_back('{data: 48'd0, lat: 1});
    start_cmd(10'd0);
    wait_result("len0");
    check("len0_no_ce", 64'(ce_count - ce0), 64'd0);

    // Result hold while consumer stalls; start pulses are ignored
    res_ready = 1'b0;
    va[0] = 18'd3; va[1] = 18'd4;
    vb[0] = 18'd3; vb[1] = 18'd4;
    exp_q.push_back('{data: 48'd25, lat: 8});
    start_cmd(10'd2);
    stream(2, 0);
    wait_result("hold");
    for (int k = 0; k < 5; k++) begin
      start = (k % 2 == 1);
      len   = 10'd3;
      @(negedge clk);
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_data",  64'(res_data),  64'd25);
      check("hold_no_ce", 64'(dsp_ce),    64'd0);
    end
    start     = 1'b0;
    len       = '0;
    res_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", 64'(res_valid), 64'd0);
    check("hold_release_busy",  64'(busy),      64'd0);

    // Back-to-back: (-1)*(-1) + 131071*131071
    va[0] = 18'h3FFFF; va[1] = 18'h1FFFF;
    vb[0] = 18'h3FFFF; vb[1] = 18'h1FFFF;
    exp_q.push_back('{data: 48'h3_FFFC_0002, lat: 8});
    start_cmd(10'd2);
    stream(2, 0);
    wait_result("b2b");

    // Abort in RUN after 2 of 4 transfers, colliding with a transfer and start
    va[0] = 18'd1; va[1] = 18'd2; va[2] = 18'd3; va[3] = 18'd4;
    vb[0] = 18'd5; vb[1] = 18'd6; vb[2] = 18'd7; vb[3] = 18'd8;
    start_cmd(10'd4);
    stream(2, 0);
    abort    = 1'b1;
    start    = 1'b1;
    len      = 10'd3;
    in_valid = 1'b1;
    in_a     = 18'd9;
    in_b     = 18'd9;
    @(negedge clk);
    abort    = 1'b0;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    check_idle("abort");
    check("abort_res_data", 64'(res_data), 64'd0);

    // Async reset while draining a new run
    va[0] = 18'd5; va[1] = 18'd6;
    vb[0] = 18'd5; vb[1] = 18'd6;
    start_cmd(10'd2);
    stream(2, 0);
    check("drain_busy",     64'(busy),     64'd1);
    check("drain_in_ready", 64'(in_ready), 64'd0);
    #2 rstn = 1'b0;
    #1 check_idle("rstn_mid");
    @(negedge clk);
    rstn = 1'b1;
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (res_valid) hits++;
    end
    check("no_res_after_abort", 64'(hits), 64'd0);

    // Fresh run: no residue from the aborted runs
    va[0] = 18'd10; va[1] = 18'd20;
    vb[0] = 18'd10; vb[1] = 18'd20;
    exp_q.push_back('{data: 48'd500, lat: 8});
    start_cmd(10'd2);
    stream(2, 0);
    wait_result("fresh");

    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
